// File: rtl/router_output_arbiter_if.sv
// Handshake bundle between NUM_IN input buffers, one output link and its credit return.
// Requesters and downstream drive the master side; the arbiter drives the slave side.
// Widths are derived from the same parameters the arbiter uses.
interface router_output_arbiter_if #(
  parameter int NUM_IN  = 5,
  parameter int FLIT_W  = 64,
  parameter int CREDITS = 4,
  parameter int IDX_W   = $clog2(NUM_IN),
  parameter int CNT_W   = $clog2(CREDITS + 1)
);
  logic [NUM_IN-1:0]        req_valid;
  logic [NUM_IN*FLIT_W-1:0] req_flit;
  logic [NUM_IN-1:0]        req_tail;
  logic [NUM_IN-1:0]        req_grant;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_tail;
  logic                     credit_in;
  logic [CNT_W-1:0]         credit_cnt;
  logic                     locked;
  logic [IDX_W-1:0]         lock_owner;
  logic                     credit_err;

  modport master (
    output req_valid, req_flit, req_tail, credit_in,
    input  req_grant, out_valid, out_flit, out_tail,
    input  credit_cnt, locked, lock_owner, credit_err
  );

  modport slave (
    input  req_valid, req_flit, req_tail, credit_in,
    output req_grant, out_valid, out_flit, out_tail,
    output credit_cnt, locked, lock_owner, credit_err
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Round-robin, wormhole-locking scheduler for one router output link with credit flow control.
// Latency: grant is combinational; the winning flit appears on out_* one cycle later.
// Backpressure: no grant while credit_cnt == 0; credit_in never reaches req_grant combinationally.
module router_output_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int FLIT_W  = 64,
  parameter int CREDITS = 4,
  parameter int IDX_W   = $clog2(NUM_IN),
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  router_output_arbiter_if.slave  io_bus
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CREDITS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_owner;
  logic [CNT_W-1:0]  r_credit;
  logic              r_credit_err;
  logic              r_out_valid;
  logic [FLIT_W-1:0] r_out_flit;
  logic              r_out_tail;

  logic              w_found;
  logic [IDX_W-1:0]  w_winner;
  logic [NUM_IN-1:0] w_grant;
  logic [FLIT_W-1:0] w_flit;
  logic              w_tail;

  // (a + k) mod NUM_IN, for a < NUM_IN and k <= NUM_IN
  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_IN) s = s - NUM_IN;
    return s[IDX_W-1:0];
  endfunction

  // Winner selection: owner only while locked, otherwise first requester from rr_ptr onward
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    if (r_credit != '0) begin
      if (r_state == ST_LOCKED) begin
        if (io_bus.req_valid[r_owner]) begin
          w_found  = 1'b1;
          w_winner = r_owner;
        end
      end else begin
        for (int k = 0; k < NUM_IN; k++) begin
          if (!w_found && io_bus.req_valid[f_wrap(r_rr_ptr, k)]) begin
            w_found  = 1'b1;
            w_winner = f_wrap(r_rr_ptr, k);
          end
        end
      end
    end
  end

  // Grant strobe and the winner's flit/tail
  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_winner] = 1'b1;
    w_flit = io_bus.req_flit[int'(w_winner)*FLIT_W +: FLIT_W];
    w_tail = io_bus.req_tail[w_winner];
  end

  // Next state: a non-tail grant opens a packet, a tail grant closes it
  always_comb begin
    w_state_nxt = r_state;
    if (w_found) begin
      if (r_state == ST_IDLE && !w_tail)  w_state_nxt = ST_LOCKED;
      if (r_state == ST_LOCKED && w_tail) w_state_nxt = ST_IDLE;
    end
  end

  // Arbitration state: FSM, round-robin pointer and lock owner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_found && r_state == ST_IDLE) r_rr_ptr <= f_wrap(w_winner, 1);
      if (w_state_nxt == ST_LOCKED) r_owner <= w_winner;
      else                          r_owner <= '0;
    end
  end

  // Credit counter, saturating both ways; overflow attempt sets a sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit     <= C_FULL;
      r_credit_err <= 1'b0;
    end else if (w_found && !io_bus.credit_in) begin
      r_credit <= r_credit - 1'b1;
    end else if (!w_found && io_bus.credit_in) begin
      if (r_credit == C_FULL) r_credit_err <= 1'b1;
      else                    r_credit     <= r_credit + 1'b1;
    end
  end

  // Output register: load the winner's flit, hold data when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_tail  <= 1'b0;
    end else begin
      r_out_valid <= w_found;
      if (w_found) begin
        r_out_flit <= w_flit;
        r_out_tail <= w_tail;
      end
    end
  end

  assign io_bus.req_grant  = w_grant;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.out_flit   = r_out_flit;
  assign io_bus.out_tail   = r_out_tail;
  assign io_bus.credit_cnt = r_credit;
  assign io_bus.locked     = (r_state == ST_LOCKED);
  assign io_bus.lock_owner = r_owner;
  assign io_bus.credit_err = r_credit_err;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: inputs change 1ns after posedge,
// outputs are checked on the negedge of the same cycle.
// Expected values are hand-derived per step.
module tb_router_output_arbiter;
  localparam int NUM_IN  = 5;
  localparam int FLIT_W  = 64;
  localparam int CREDITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  router_output_arbiter_if #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .CREDITS(CREDITS)) bus ();

  router_output_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  function automatic logic [63:0] fl(input int p, input int n);
    return 64'hA5A5_0000_0000_0000 | (64'(p) << 12) | 64'(n);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic [63:0] f, input logic t);
    bus.req_valid[p] = v;
    bus.req_flit[p*FLIT_W +: FLIT_W] = f;
    bus.req_tail[p] = t;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_flit  = '0;
    bus.req_tail  = '0;
    bus.credit_in = 1'b0;
  endtask

  // move to checking point of current cycle
  task automatic at_check();
    @(negedge clk);
  endtask

  // move to drive point of next cycle
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // ---- reset state ----
    at_check();
    chk("rst_grant", 64'(bus.req_grant), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_flit", bus.out_flit, 64'h0);
    chk("rst_out_tail", 64'(bus.out_tail), 64'h0);
    chk("rst_credit", 64'(bus.credit_cnt), 64'd4);
    chk("rst_locked", 64'(bus.locked), 64'h0);
    chk("rst_owner", 64'(bus.lock_owner), 64'h0);
    chk("rst_err", 64'(bus.credit_err), 64'h0);
    chk("rst_rr", 64'(dut.r_rr_ptr), 64'd0);

    // ---- 1: two single-flit requesters, held ----
    next_cyc();
    set_port(0, 1'b1, fl(0, 0), 1'b1);
    set_port(2, 1'b1, fl(2, 0), 1'b1);
    at_check();
    chk("t1_grant_t0", 64'(bus.req_grant), 64'h01);
    next_cyc();
    at_check();
    chk("t1_grant_t1", 64'(bus.req_grant), 64'h04);
    chk("t1_outv_t1", 64'(bus.out_valid), 64'h1);
    chk("t1_flit_t1", bus.out_flit, fl(0, 0));
    next_cyc();
    clear_inputs();
    at_check();
    chk("t1_flit_t2", bus.out_flit, fl(2, 0));
    chk("t1_tail_t2", 64'(bus.out_tail), 64'h1);
    chk("t1_rr", 64'(dut.r_rr_ptr), 64'd3);
    chk("t1_credit", 64'(bus.credit_cnt), 64'd2);
    next_cyc();
    at_check();
    chk("t1_outv_idle", 64'(bus.out_valid), 64'h0);
    chk("t1_flit_hold", bus.out_flit, fl(2, 0));

    // ---- 2: wormhole lock against a competing requester ----
    do_reset();
    set_port(1, 1'b1, fl(1, 0), 1'b0);
    set_port(3, 1'b1, fl(3, 0), 1'b1);
    at_check();
    chk("t2_grant_a", 64'(bus.req_grant), 64'h02);
    chk("t2_locked_a", 64'(bus.locked), 64'h0);
    next_cyc();
    set_port(1, 1'b1, fl(1, 1), 1'b0);
    at_check();
    chk("t2_locked_b", 64'(bus.locked), 64'h1);
    chk("t2_owner_b", 64'(bus.lock_owner), 64'd1);
    chk("t2_grant_b", 64'(bus.req_grant), 64'h02);
    chk("t2_flit_b", bus.out_flit, fl(1, 0));
    chk("t2_tail_b", 64'(bus.out_tail), 64'h0);
    next_cyc();
    set_port(1, 1'b1, fl(1, 2), 1'b1);
    at_check();
    chk("t2_locked_c", 64'(bus.locked), 64'h1);
    chk("t2_owner_c", 64'(bus.lock_owner), 64'd1);
    chk("t2_grant_c", 64'(bus.req_grant), 64'h02);
    chk("t2_flit_c", bus.out_flit, fl(1, 1));
    next_cyc();
    set_port(1, 1'b0, 64'h0, 1'b0);
    at_check();
    chk("t2_locked_d", 64'(bus.locked), 64'h0);
    chk("t2_owner_d", 64'(bus.lock_owner), 64'd0);
    chk("t2_grant_d", 64'(bus.req_grant), 64'h08);
    chk("t2_flit_d", bus.out_flit, fl(1, 2));
    chk("t2_tail_d", 64'(bus.out_tail), 64'h1);
    next_cyc();
    at_check();
    chk("t2_flit_e", bus.out_flit, fl(3, 0));
    chk("t2_credit_e", 64'(bus.credit_cnt), 64'd0);
    chk("t2_grant_e", 64'(bus.req_grant), 64'h00);

    // ---- 3: credit exhaustion and one-credit refill ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1'b1, fl(0, i), 1'b1);
      at_check();
      chk("t3_grant", 64'(bus.req_grant), 64'h01);
      chk("t3_credit", 64'(bus.credit_cnt), 64'(4 - i));
      next_cyc();
    end
    set_port(0, 1'b1, fl(0, 4), 1'b1);
    at_check();
    chk("t3_stall_grant", 64'(bus.req_grant), 64'h00);
    chk("t3_stall_credit", 64'(bus.credit_cnt), 64'd0);
    next_cyc();
    bus.credit_in = 1'b1;
    at_check();
    chk("t3_credit_in_nocomb", 64'(bus.req_grant), 64'h00);
    next_cyc();
    bus.credit_in = 1'b0;
    at_check();
    chk("t3_refill_grant", 64'(bus.req_grant), 64'h01);
    chk("t3_refill_credit", 64'(bus.credit_cnt), 64'd1);
    next_cyc();
    set_port(0, 1'b1, fl(0, 5), 1'b1);
    at_check();
    chk("t3_after_grant", 64'(bus.req_grant), 64'h00);
    chk("t3_after_credit", 64'(bus.credit_cnt), 64'd0);
    chk("t3_after_flit", bus.out_flit, fl(0, 4));

    // ---- 4: credit boundaries ----
    next_cyc();
    set_port(0, 1'b0, 64'h0, 1'b0);
    bus.credit_in = 1'b1;
    next_cyc();
    next_cyc();
    set_port(0, 1'b1, fl(0, 5), 1'b1);
    at_check();
    chk("t4_pre_credit", 64'(bus.credit_cnt), 64'd2);
    chk("t4_both_grant", 64'(bus.req_grant), 64'h01);
    next_cyc();
    clear_inputs();
    at_check();
    chk("t4_both_credit", 64'(bus.credit_cnt), 64'd2);
    next_cyc();
    bus.credit_in = 1'b1;
    next_cyc();
    next_cyc();
    at_check();
    chk("t4_full_credit", 64'(bus.credit_cnt), 64'd4);
    chk("t4_err_before", 64'(bus.credit_err), 64'h0);
    next_cyc();
    bus.credit_in = 1'b0;
    at_check();
    chk("t4_sat_credit", 64'(bus.credit_cnt), 64'd4);
    chk("t4_err_set", 64'(bus.credit_err), 64'h1);
    next_cyc();
    next_cyc();
    at_check();
    chk("t4_err_sticky", 64'(bus.credit_err), 64'h1);

    // ---- 5: round-robin wrap ----
    do_reset();
    chk("t5_err_cleared", 64'(bus.credit_err), 64'h0);
    set_port(4, 1'b1, fl(4, 0), 1'b1);
    at_check();
    chk("t5_grant4", 64'(bus.req_grant), 64'h10);
    next_cyc();
    set_port(4, 1'b0, 64'h0, 1'b0);
    at_check();
    chk("t5_rr_wrap", 64'(dut.r_rr_ptr), 64'd0);
    next_cyc();
    set_port(0, 1'b1, fl(0, 7), 1'b1);
    set_port(4, 1'b1, fl(4, 7), 1'b1);
    at_check();
    chk("t5_grant0", 64'(bus.req_grant), 64'h01);
    next_cyc();
    at_check();
    chk("t5_grant4_again", 64'(bus.req_grant), 64'h10);
    chk("t5_flit0", bus.out_flit, fl(0, 7));

    // ---- 6: reset while locked ----
    do_reset();
    set_port(2, 1'b1, fl(2, 0), 1'b0);
    at_check();
    chk("t6_grant2", 64'(bus.req_grant), 64'h04);
    next_cyc();
    set_port(2, 1'b1, fl(2, 1), 1'b0);
    at_check();
    chk("t6_locked", 64'(bus.locked), 64'h1);
    chk("t6_owner", 64'(bus.lock_owner), 64'd2);
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    set_port(0, 1'b1, fl(0, 9), 1'b1);
    set_port(2, 1'b1, fl(2, 9), 1'b1);
    at_check();
    chk("t6_unlocked", 64'(bus.locked), 64'h0);
    chk("t6_owner_clr", 64'(bus.lock_owner), 64'd0);
    chk("t6_credit", 64'(bus.credit_cnt), 64'd4);
    chk("t6_outv", 64'(bus.out_valid), 64'h0);
    chk("t6_grant0", 64'(bus.req_grant), 64'h01);
    next_cyc();
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
